// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the memory/bus interface stage: FSM states, the kind of
// access being serialised, and the width of the per-beat wait counter.
package vc16_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OPK_FETCH = 2'd0,
    OPK_READ  = 2'd1,
    OPK_WRITE = 2'd2
  } opk_t;

  // Wide enough for WAIT values 0..15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Narrow 8-bit SRAM/IO-style external bus. The controller drives it through
// the master modport; the memory or IO device sits on the slave side.
interface mem_bus_ctrl_if #(
  parameter int VA = 16
);
  logic          mem_req;
  logic          mem_we;
  logic          mem_io;
  logic [VA-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_io, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_io, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory/bus interface stage behind execute. Arbitrates between write, read
// and fetch requests, serialises the chosen access into one or two byte beats
// on the external 8-bit bus, and returns a one-cycle done pulse with the
// assembled read data or instruction word. All bus outputs are registered so
// they hold steady for the whole of every cycle with mem_req high.
module mem_bus_ctrl
  import vc16_bus_pkg::*;
#(
  parameter int RV   = 16,
  parameter int VA   = 16,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifetch,
  input  logic [VA-2:0] pc,
  input  logic [1:0]    rstrobe,
  input  logic [1:0]    wmask,
  input  logic [VA-2:0] addr,
  input  logic [RV-1:0] wdata,
  input  logic          io_access,
  output logic          idone,
  output logic          rdone,
  output logic          wdone,
  output logic [RV-1:0] rdata,
  output logic [RV-1:0] insn,
  mem_bus_ctrl_if.master bus
);

  state_t              state_reg;
  opk_t                op_reg;
  logic [VA-2:0]       waddr_reg;
  logic [1:0]          ben_reg;
  logic [7:0]          wdata_hi_reg;
  logic [7:0]          lo_byte_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;

  logic                mem_req_reg;
  logic                mem_we_reg;
  logic                mem_io_reg;
  logic [VA-1:0]       mem_addr_reg;
  logic [7:0]          mem_wdata_reg;
  logic                idone_reg;
  logic                rdone_reg;
  logic                wdone_reg;
  logic [RV-1:0]       rdata_reg;
  logic [RV-1:0]       insn_reg;

  // Arbitration result for the request set currently presented in IDLE.
  logic                arb_req;
  opk_t                arb_op;
  logic [1:0]          arb_ben;
  logic [VA-2:0]       arb_addr;
  logic                arb_sel;

  // Beat handshake: the wait counter must have drained before ack counts.
  logic                beat_done;
  logic                more_beats;

  // Priority write > read > fetch; fetch always moves a whole word.
  always_comb begin
    arb_req  = (|wmask) | (|rstrobe) | ifetch;
    arb_op   = OPK_FETCH;
    arb_ben  = 2'b11;
    arb_addr = pc;
    if (|wmask) begin
      arb_op   = OPK_WRITE;
      arb_ben  = wmask;
      arb_addr = addr;
    end else if (|rstrobe) begin
      arb_op   = OPK_READ;
      arb_ben  = rstrobe;
      arb_addr = addr;
    end
    // Lo byte goes first when enabled, otherwise the lone hi byte.
    arb_sel = ~arb_ben[0];
  end

  // A second beat is only ever the hi byte following a lo byte.
  always_comb begin
    beat_done  = (wait_cnt_reg == '0) && bus.mem_ack;
    more_beats = (state_reg == BEAT0) && (ben_reg == 2'b11);
  end

  // Main FSM with all outputs registered.
  always_ff @(posedge clk) begin
    idone_reg <= 1'b0;
    rdone_reg <= 1'b0;
    wdone_reg <= 1'b0;
    if (!reset) begin
      state_reg     <= IDLE;
      op_reg        <= OPK_FETCH;
      waddr_reg     <= '0;
      ben_reg       <= '0;
      wdata_hi_reg  <= '0;
      lo_byte_reg   <= '0;
      wait_cnt_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_io_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
      insn_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_req) begin
            op_reg        <= arb_op;
            waddr_reg     <= arb_addr;
            ben_reg       <= arb_ben;
            wdata_hi_reg  <= wdata[15:8];
            wait_cnt_reg  <= WAIT_W'(WAIT);
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= (arb_op == OPK_WRITE);
            mem_io_reg    <= (arb_op != OPK_FETCH) && io_access;
            mem_addr_reg  <= {arb_addr, arb_sel};
            mem_wdata_reg <= arb_sel ? wdata[15:8] : wdata[7:0];
            state_reg     <= BEAT0;
          end
        end

        BEAT0, BEAT1: begin
          if (wait_cnt_reg != '0) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end else if (beat_done) begin
            if (more_beats) begin
              lo_byte_reg   <= bus.mem_rdata;
              wait_cnt_reg  <= WAIT_W'(WAIT);
              mem_addr_reg  <= {waddr_reg, 1'b1};
              mem_wdata_reg <= wdata_hi_reg;
              state_reg     <= BEAT1;
            end else begin
              mem_req_reg <= 1'b0;
              mem_we_reg  <= 1'b0;
              mem_io_reg  <= 1'b0;
              case (op_reg)
                OPK_WRITE: wdone_reg <= 1'b1;
                OPK_READ: begin
                  rdone_reg <= 1'b1;
                  // Single-byte reads land in the low byte for execute to extend.
                  rdata_reg <= (ben_reg == 2'b11) ? {bus.mem_rdata, lo_byte_reg}
                                                  : {8'h00, bus.mem_rdata};
                end
                default: begin
                  idone_reg <= 1'b1;
                  insn_reg  <= {bus.mem_rdata, lo_byte_reg};
                end
              endcase
              state_reg <= DONE;
            end
          end
        end

        // Requests are still high here, so never re-arbitrate from DONE.
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_io    = mem_io_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign idone         = idone_reg;
  assign rdone         = rdone_reg;
  assign wdone         = wdone_reg;
  assign rdata         = rdata_reg;
  assign insn          = insn_reg;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory/bus interface stage directly downstream of the execute stage.
- Accepts the execute stage's held-level requests: instruction fetch, data read (byte strobes) and data write (byte mask).
- Serialises each request onto a narrow 8-bit SRAM/IO-style external bus as one or two byte beats.
- Returns one-cycle done pulses, read data and the fetched instruction word (to decode).

Parameters:
- RV, 16, datapath width in bits; only 16 is supported.
- VA, 16, virtual address width in bits; the external byte address is VA bits.
- WAIT, 0, minimum extra cycles per beat before mem_ack is honoured (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ifetch  in  1  fetch request, held until idone
- pc  in  VA-1  word address of the instruction to fetch
- rstrobe  in  2  read byte strobes {hi,lo}, held until rdone
- wmask  in  2  write byte mask {hi,lo}, held until wdone
- addr  in  VA-1  data word address
- wdata  in  16  write data; bits [15:8] go to the hi byte, bits [7:0] to the lo byte
- io_access  in  1  data access targets IO space
- idone  out  1  one-cycle pulse: fetch complete
- rdone  out  1  one-cycle pulse: read complete
- wdone  out  1  one-cycle pulse: write complete
- rdata  out  16  read data, valid during rdone and held after
- insn  out  16  fetched instruction, valid during idone and held after
- mem_req  out  1  external beat request
- mem_we  out  1  beat is a write
- mem_io  out  1  beat targets IO space
- mem_addr  out  VA  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte
- mem_ack  in  1  external beat acknowledge

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - mem_req, mem_we, mem_io, idone, rdone, wdone = 0.
  - mem_addr, mem_wdata, rdata, insn = 0.
  - The wait counter is cleared.
  - Reset mid-access abandons the access: no done pulse, mem_req drops on the next cycle.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: arbitration and latching.
  - Priority when several requests are present: write (|wmask) > read (|rstrobe) > fetch.
  - Latch the op kind, the word address, the byte-enable set and wdata.
  - Latch mem_io = io_access for data ops; mem_io = 0 for fetch.
  - Fetch uses enables 2'b11.
  - Go to BEAT0, issuing the first enabled byte (lo before hi).
- BEAT0 / BEAT1:
  - mem_req=1; mem_addr = {word address, byte select}; mem_we = (op==write).
  - mem_wdata = the selected wdata byte.
  - The wait counter loads WAIT on beat entry and decrements to 0.
  - The beat completes on the edge where counter==0 && mem_ack.
  - On a read or fetch completion, capture mem_rdata into that beat's byte slot.
  - If a second enabled byte remains, go to BEAT1 (hi byte, address+1); otherwise go to DONE.
  - mem_ack while the counter is nonzero is ignored.
- DONE (one cycle):
  - mem_req=0; pulse exactly one of idone/rdone/wdone.
  - Always return to IDLE; do not re-arbitrate in DONE, since requests are still high that cycle.
- Read data placement:
  - Both strobes: rdata = {hi byte, lo byte}.
  - Single strobe: the selected byte is placed in rdata[7:0] and rdata[15:8]=0. Execute sign/zero-extends from bit 7.
- Fetch data placement: insn = {byte at 2*pc+1, byte at 2*pc}, little-endian.
- Latency, WAIT=0, mem_ack tied high:
  - Two-beat access: done asserted 3 cycles after the request is first seen in IDLE.
  - One-beat access: done asserted 2 cycles after.
- Request dropped mid-access (not legal from execute): the latched sequence completes and the done pulse is still issued.
- Both wmask bits zero and both rstrobe bits zero with ifetch=0: stay in IDLE.
- Address wrap: the byte address increments modulo 2^VA. Within a word the pair is {addr,0},{addr,1}, so no carry is possible.
- mem_addr/mem_we/mem_io/mem_wdata are stable for the whole of every cycle with mem_req=1.

Decomposition:
- Package vc16_bus_pkg:
  - state enum (IDLE, BEAT0, BEAT1, DONE);
  - op-kind enum (OPK_FETCH, OPK_READ, OPK_WRITE);
  - the WAIT counter width constant (4).
- Single module. The wait counter and byte steering are inline, so no sub-module is warranted.

Test Plan:
- Fetch, pc=0x0010, mem_rdata 0x34 then 0x12, ack high, WAIT=0 -> beats at mem_addr 0x0020 then 0x0021; idone exactly 3 cycles after request; insn=0x1234.
- Byte read, rstrobe=2'b10, addr=0x0040, mem_rdata=0x9A -> single beat at 0x0081; rdone after 2 cycles; rdata=0x009A.
- Word write, wmask=2'b11, wdata=0xBEEF, io_access=1 -> beats write 0xEF@0x0080 then 0xBE@0x0081, mem_io=1 and mem_we=1 on both; one wdone pulse.
- WAIT=2, mem_ack held low 5 cycles -> mem_req and address stable throughout; beat completes only when counter==0 and ack is high.
- wmask=2'b01 and ifetch=1 both asserted -> write serviced first (wdone), then fetch starts from IDLE.
- reset low during BEAT1 -> next cycle mem_req=0, no done pulse, all outputs 0; the next request completes normally.
